// File: rtl/xga_timing_pipeline.sv
// ============================================================================
// Module   : xga_timing_pipeline
// Brief    : Parametrised raster timing generator with latency-matched pixel
//            output stage and built-in colour-bar pattern.
// Revision : 1.0
// ============================================================================
`default_nettype none

module xga_timing_pipeline #(
    parameter int H_ACTIVE       = 1024,
    parameter int H_FP           = 24,
    parameter int H_SYNC         = 136,
    parameter int H_BP           = 160,
    parameter int V_ACTIVE       = 768,
    parameter int V_FP           = 3,
    parameter int V_SYNC         = 6,
    parameter int V_BP           = 29,
    parameter int HS_ACTIVE_HIGH = 0,
    parameter int VS_ACTIVE_HIGH = 0,
    parameter int PIPE_DELAY     = 0,
    parameter int COLOR_W        = 8
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             ce,
    input  logic                                             pattern_en,
    input  logic [COLOR_W-1:0]                               pix_r,
    input  logic [COLOR_W-1:0]                               pix_g,
    input  logic [COLOR_W-1:0]                               pix_b,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]     x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]     y,
    output logic                                             active,
    output logic                                             frame_start,
    output logic                                             line_start,
    output logic [COLOR_W-1:0]                               VGA_R,
    output logic [COLOR_W-1:0]                               VGA_G,
    output logic [COLOR_W-1:0]                               VGA_B,
    output logic                                             VGA_BLANK_N,
    output logic                                             VGA_SYNC_N,
    output logic                                             VGA_HS,
    output logic                                             VGA_VS
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);

    localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_HS_BEG   = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_HW-1:0] c_H_ONE    = c_HW'(1);
    localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_VS_BEG   = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_VW-1:0] c_V_ONE    = c_VW'(1);
    localparam logic            c_HS_ON    = (HS_ACTIVE_HIGH != 0);
    localparam logic            c_VS_ON    = (VS_ACTIVE_HIGH != 0);

    generate
        if (H_ACTIVE < 8 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
            COLOR_W < 1 || PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_params
            $error("xga_timing_pipeline: illegal parameter set");
        end
    endgenerate

    logic [c_HW-1:0]    r_h;
    logic [c_VW-1:0]    r_v;
    logic               w_active;
    logic               w_hs0;
    logic               w_vs0;
    logic               w_hs_d;
    logic               w_vs_d;
    logic               w_act_d;
    logic [c_HW-1:0]    w_x_d;
    logic [c_HW+2:0]    w_x8;
    logic [2:0]         w_bar;
    logic [COLOR_W-1:0] w_r;
    logic [COLOR_W-1:0] w_g;
    logic [COLOR_W-1:0] w_b;
    logic [COLOR_W-1:0] r_r;
    logic [COLOR_W-1:0] r_g;
    logic [COLOR_W-1:0] r_b;
    logic               r_blank_n;
    logic               r_hs;
    logic               r_vs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (ce) begin
            if (r_h == c_H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == c_V_LAST) ? '0 : r_v + c_V_ONE;
            end else begin
                r_h <= r_h + c_H_ONE;
            end
        end
    end

    assign w_active    = (r_h < c_H_ACT) && (r_v < c_V_ACT);
    assign w_hs0       = ((r_h >= c_HS_BEG) && (r_h < c_HS_END)) ? c_HS_ON : ~c_HS_ON;
    assign w_vs0       = ((r_v >= c_VS_BEG) && (r_v < c_VS_END)) ? c_VS_ON : ~c_VS_ON;
    assign x           = r_h;
    assign y           = r_v;
    assign active      = w_active;
    assign line_start  = ce && (r_h == '0);
    assign frame_start = ce && (r_h == '0) && (r_v == '0);

    // Stage-0 timing is delayed to meet colour arriving from the drawing pipe.
    generate
        if (PIPE_DELAY == 0) begin : g_nodelay
            assign w_hs_d  = w_hs0;
            assign w_vs_d  = w_vs0;
            assign w_act_d = w_active;
            assign w_x_d   = r_h;
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] r_hs_sr;
            logic [PIPE_DELAY-1:0] r_vs_sr;
            logic [PIPE_DELAY-1:0] r_act_sr;
            logic [c_HW-1:0]       r_x_sr [PIPE_DELAY];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_hs_sr  <= {PIPE_DELAY{~c_HS_ON}};
                    r_vs_sr  <= {PIPE_DELAY{~c_VS_ON}};
                    r_act_sr <= '0;
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        r_x_sr[i] <= '0;
                    end
                end else if (ce) begin
                    r_hs_sr[0]  <= w_hs0;
                    r_vs_sr[0]  <= w_vs0;
                    r_act_sr[0] <= w_active;
                    r_x_sr[0]   <= r_h;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        r_hs_sr[i]  <= r_hs_sr[i-1];
                        r_vs_sr[i]  <= r_vs_sr[i-1];
                        r_act_sr[i] <= r_act_sr[i-1];
                        r_x_sr[i]   <= r_x_sr[i-1];
                    end
                end
            end

            assign w_hs_d  = r_hs_sr[PIPE_DELAY-1];
            assign w_vs_d  = r_vs_sr[PIPE_DELAY-1];
            assign w_act_d = r_act_sr[PIPE_DELAY-1];
            assign w_x_d   = r_x_sr[PIPE_DELAY-1];
        end
    endgenerate

    // Bar index = floor(x*8/H_ACTIVE): x*8 is a shift, thresholds are constants.
    assign w_x8 = {w_x_d, 3'b000};

    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (w_x8 >= (c_HW+3)'(k * H_ACTIVE)) begin
                w_bar = 3'(k);
            end
        end
    end

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (w_act_d) begin
            if (pattern_en) begin
                w_r = {COLOR_W{~w_bar[1]}};
                w_g = {COLOR_W{~w_bar[2]}};
                w_b = {COLOR_W{~w_bar[0]}};
            end else begin
                w_r = pix_r;
                w_g = pix_g;
                w_b = pix_b;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
            r_blank_n <= 1'b0;
            r_hs      <= ~c_HS_ON;
            r_vs      <= ~c_VS_ON;
        end else if (ce) begin
            r_r       <= w_r;
            r_g       <= w_g;
            r_b       <= w_b;
            r_blank_n <= w_act_d;
            r_hs      <= w_hs_d;
            r_vs      <= w_vs_d;
        end
    end

    assign VGA_R       = r_r;
    assign VGA_G       = r_g;
    assign VGA_B       = r_b;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;

endmodule

`default_nettype wire

// File: tb/tb_xga_timing_pipeline.sv
// ============================================================================
// Module   : tb_xga_timing_pipeline
// Brief    : Self-checking bench: XGA default, small mode and delayed small mode
//            instances compared against an arithmetic raster model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_xga_timing_pipeline;

    localparam int HIST = 4096;

    logic clk = 1'b0;
    logic reset;
    logic ce;
    logic pe_x, pe_0, pe_3;
    logic [7:0] pr_x, pg_x, pb_x, pr_0, pg_0, pb_0, pr_3, pg_3, pb_3;

    logic [10:0] x_x;  logic [9:0] y_x;
    logic [3:0]  x_0;  logic [2:0] y_0;
    logic [3:0]  x_3;  logic [2:0] y_3;
    logic act_x, fs_x, ls_x, bn_x, sn_x, hs_x, vs_x;
    logic act_0, fs_0, ls_0, bn_0, sn_0, hs_0, vs_0;
    logic act_3, fs_3, ls_3, bn_3, sn_3, hs_3, vs_3;
    logic [7:0] r_x, g_x, b_x, r_0, g_0, b_0, r_3, g_3, b_3;

    int total = 0;
    int bad   = 0;
    int n;
    int fs_cnt0, last_fs0, ls0, ls3, rise0, rise3;
    logic hs0_prev, hs3_prev;
    logic [23:0] pixh_x [HIST];
    logic [23:0] pixh_0 [HIST];
    logic [23:0] pixh_3 [HIST];
    bit          path_x [HIST];
    bit          path_0 [HIST];

    always #5 clk = ~clk;

    xga_timing_pipeline u_xga (
        .clk(clk), .reset(reset), .ce(ce), .pattern_en(pe_x),
        .pix_r(pr_x), .pix_g(pg_x), .pix_b(pb_x),
        .x(x_x), .y(y_x), .active(act_x), .frame_start(fs_x), .line_start(ls_x),
        .VGA_R(r_x), .VGA_G(g_x), .VGA_B(b_x), .VGA_BLANK_N(bn_x),
        .VGA_SYNC_N(sn_x), .VGA_HS(hs_x), .VGA_VS(vs_x)
    );

    xga_timing_pipeline #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_ACTIVE_HIGH(1), .VS_ACTIVE_HIGH(1), .PIPE_DELAY(0), .COLOR_W(8)
    ) u_s0 (
        .clk(clk), .reset(reset), .ce(ce), .pattern_en(pe_0),
        .pix_r(pr_0), .pix_g(pg_0), .pix_b(pb_0),
        .x(x_0), .y(y_0), .active(act_0), .frame_start(fs_0), .line_start(ls_0),
        .VGA_R(r_0), .VGA_G(g_0), .VGA_B(b_0), .VGA_BLANK_N(bn_0),
        .VGA_SYNC_N(sn_0), .VGA_HS(hs_0), .VGA_VS(vs_0)
    );

    xga_timing_pipeline #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_ACTIVE_HIGH(1), .VS_ACTIVE_HIGH(1), .PIPE_DELAY(3), .COLOR_W(8)
    ) u_s3 (
        .clk(clk), .reset(reset), .ce(ce), .pattern_en(pe_3),
        .pix_r(pr_3), .pix_g(pg_3), .pix_b(pb_3),
        .x(x_3), .y(y_3), .active(act_3), .frame_start(fs_3), .line_start(ls_3),
        .VGA_R(r_3), .VGA_G(g_3), .VGA_B(b_3), .VGA_BLANK_N(bn_3),
        .VGA_SYNC_N(sn_3), .VGA_HS(hs_3), .VGA_VS(vs_3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stage-0 view: counters follow directly from the number of ce edges.
    task automatic check_combo(input string nm, input int ht, input int vt, input int ha,
                               input int va, input logic [31:0] xo, input logic [31:0] yo,
                               input logic ao, input logic fso, input logic lso);
        int h, v;
        h = n % ht;
        v = (n / ht) % vt;
        chk({nm, "_x"}, xo, h);
        chk({nm, "_y"}, yo, v);
        chk({nm, "_active"}, 32'(ao), 32'(h < ha && v < va));
        chk({nm, "_frame_start"}, 32'(fso), 32'(ce && h == 0 && v == 0));
        chk({nm, "_line_start"}, 32'(lso), 32'(ce && h == 0));
    endtask

    // Pin view: pixel issued d+1 ce edges ago, colour sampled on the latest edge.
    task automatic check_reg(input string nm, input int ha, input int hf, input int hsw,
                             input int hb, input int va, input int vf, input int vsw,
                             input int vb, input int d, input bit hhi, input bit vhi,
                             input bit pat, input logic [23:0] pix,
                             input logic [23:0] rgb_o, input logic bl_o, input logic sn_o,
                             input logic hs_o, input logic vs_o);
        int ht, vt, m, h, v;
        bit act;
        logic [23:0] e_rgb;
        logic e_hs, e_vs;
        bit [2:0] tbl [8];
        bit [2:0] c;
        tbl = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        m  = n - 1 - d;
        if (m < 0) begin
            act = 1'b0; e_rgb = '0; e_hs = !hhi; e_vs = !vhi;
        end else begin
            h = m % ht;
            v = (m / ht) % vt;
            act  = (h < ha) && (v < va);
            e_hs = (h >= ha + hf && h < ha + hf + hsw) ? hhi : !hhi;
            e_vs = (v >= va + vf && v < va + vf + vsw) ? vhi : !vhi;
            if (!act) e_rgb = '0;
            else if (pat) begin
                c = tbl[h * 8 / ha];
                e_rgb = {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
            end else e_rgb = pix;
        end
        chk({nm, "_rgb"}, 32'(rgb_o), 32'(e_rgb));
        chk({nm, "_blank_n"}, 32'(bl_o), 32'(act));
        chk({nm, "_sync_n"}, 32'(sn_o), 32'd0);
        chk({nm, "_hs"}, 32'(hs_o), 32'(e_hs));
        chk({nm, "_vs"}, 32'(vs_o), 32'(e_vs));
    endtask

    task automatic step(input bit ce_v, input bit pex, input bit pe0);
        ce   = ce_v;
        pe_x = pex;
        pe_0 = pe0;
        {pr_x, pg_x, pb_x} = 24'($urandom);
        {pr_0, pg_0, pb_0} = 24'($urandom);
        {pg_3, pb_3}       = 16'($urandom);
        pr_3 = (n >= 3) ? 8'((n - 3) % 15) : 8'h00;
        if (ce_v && n + 1 < HIST) begin
            pixh_x[n+1] = {pr_x, pg_x, pb_x};
            pixh_0[n+1] = {pr_0, pg_0, pb_0};
            pixh_3[n+1] = {pr_3, pg_3, pb_3};
            path_x[n+1] = pex;
            path_0[n+1] = pe0;
        end
        #1;
        check_combo("xga", 1344, 806, 1024, 768, 32'(x_x), 32'(y_x), act_x, fs_x, ls_x);
        check_combo("s0", 15, 8, 8, 4, 32'(x_0), 32'(y_0), act_0, fs_0, ls_0);
        check_combo("s3", 15, 8, 8, 4, 32'(x_3), 32'(y_3), act_3, fs_3, ls_3);
        if (ls_0 === 1'b1) ls0 = n;
        if (ls_3 === 1'b1) ls3 = n;
        if (fs_0 === 1'b1) begin
            fs_cnt0++;
            if (last_fs0 >= 0) chk("s0_frame_period", n - last_fs0, 120);
            last_fs0 = n;
        end
        @(posedge clk);
        #1;
        if (ce_v) n++;
        check_reg("xga", 1024, 24, 136, 160, 768, 3, 6, 29, 0, 1'b0, 1'b0,
                  path_x[n], pixh_x[n], {r_x, g_x, b_x}, bn_x, sn_x, hs_x, vs_x);
        check_reg("s0", 8, 2, 3, 2, 4, 1, 2, 1, 0, 1'b1, 1'b1,
                  path_0[n], pixh_0[n], {r_0, g_0, b_0}, bn_0, sn_0, hs_0, vs_0);
        check_reg("s3", 8, 2, 3, 2, 4, 1, 2, 1, 3, 1'b1, 1'b1,
                  1'b0, pixh_3[n], {r_3, g_3, b_3}, bn_3, sn_3, hs_3, vs_3);
        if (hs_0 === 1'b1 && hs0_prev === 1'b0) begin
            chk("s0_hs_delay", n - ls0, 11);
            rise0 = n;
        end
        if (hs_0 === 1'b0 && hs0_prev === 1'b1) chk("s0_hs_width", n - rise0, 3);
        if (hs_3 === 1'b1 && hs3_prev === 1'b0) begin
            chk("s3_hs_delay", n - ls3, 14);
            rise3 = n;
        end
        if (hs_3 === 1'b0 && hs3_prev === 1'b1) chk("s3_hs_width", n - rise3, 3);
        hs0_prev = hs_0;
        hs3_prev = hs_3;
        if (bn_3 === 1'b1 && n >= 4) chk("s3_align", 32'(r_3), 32'((n - 4) % 15));
        if (path_x[n]) begin
            if (n == 128)  chk("bar_px127", 32'({r_x, g_x, b_x}), 32'h00FFFFFF);
            if (n == 129)  chk("bar_px128", 32'({r_x, g_x, b_x}), 32'h00FFFF00);
            if (n == 1024) chk("bar_px1023", 32'({r_x, g_x, b_x}), 32'h00000000);
            if (n == 1025) chk("bar_px1024_blank", 32'({bn_x, r_x, g_x, b_x}), 32'h0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_xga_xy", {x_x, y_x}, 0);
        chk("rst_xga_pins", 32'({r_x, g_x, b_x, bn_x, hs_x, vs_x}), 32'h3);
        chk("rst_s0_xy", {x_0, y_0}, 0);
        chk("rst_s0_pins", 32'({r_0, g_0, b_0, bn_0, hs_0, vs_0}), 32'h0);
        chk("rst_s3_pins", 32'({r_3, g_3, b_3, bn_3, hs_3, vs_3}), 32'h0);
        n        = 0;
        fs_cnt0  = 0;
        last_fs0 = -1;
        ls0      = 0;
        ls3      = 0;
        rise0    = 0;
        rise3    = 0;
        hs0_prev = 1'b0;
        hs3_prev = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ce    = 1'b0;
        pe_x  = 1'b1; pe_0 = 1'b0; pe_3 = 1'b0;
        {pr_x, pg_x, pb_x, pr_0, pg_0, pb_0, pr_3, pg_3, pb_3} = '0;
        for (int i = 0; i < HIST; i++) begin
            pixh_x[i] = '0; pixh_0[i] = '0; pixh_3[i] = '0;
            path_x[i] = 1'b0; path_0[i] = 1'b0;
        end
        n = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Continuous ce: XGA colour bars on line 0, small-mode line/frame timing.
        for (int i = 0; i < 1400; i++) step(1'b1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of an XGA line.
        #2;
        do_reset();

        // Alternating ce over two small-mode frame lengths of clocks.
        for (int i = 0; i < 240; i++) step((i % 2) == 0, 1'b1, 1'b0);
        chk("s0_one_frame_start_at_half_ce", fs_cnt0, 1);

        // Explicit 1,0,0,1 gap, then random ce, pattern and pixels.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
